// File: rtl/ping_pong_pkg.sv
// Shared game-state encodings, winner codes and small arithmetic helpers
// used by the match controller and every game-state consumer.
package ping_pong_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned WIN_W   = 2;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned TIME_W  = 6;
    localparam int unsigned BALL_W  = 10;

    typedef enum logic [STATE_W-1:0] {
        ST_SERVE   = 2'd0,
        ST_PLAYING = 2'd1,
        ST_DONE    = 2'd2,
        ST_POINT   = 2'd3
    } game_state_e;

    typedef enum logic [WIN_W-1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_TIE  = 2'd3
    } winner_e;

    // One press pulse per player button.
    typedef struct packed {
        logic p1l;
        logic p1r;
        logic p2l;
        logic p2r;
    } btn_press_t;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + SCORE_W'(1);
    endfunction

    function automatic logic [TIME_W-1:0] time_inc(input logic [TIME_W-1:0] t);
        return (t == '1) ? t : t + TIME_W'(1);
    endfunction

    function automatic winner_e pick_winner(input logic [SCORE_W-1:0] s1,
                                            input logic [SCORE_W-1:0] s2);
        if (s1 > s2) begin
            return WIN_P1;
        end else if (s2 > s1) begin
            return WIN_P2;
        end
        return WIN_TIE;
    endfunction

endpackage

// File: rtl/match_sequencer_btn_press_sync.sv
// Active-low button synchroniser (2 FF) with falling-edge detector; emits a
// single-cycle press pulse per press however long the button is held.
module btn_press_sync
    import ping_pong_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_c_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Preset to released so a button held through reset does not fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_c_o = prev_q & ~sync2_q;

endmodule

// File: rtl/match_sequencer.sv
// Central ping-pong game controller: serve/rally/point/done sequencing,
// scoring, match clock and server selection.
module match_sequencer
    import ping_pong_pkg::*;
#(
    parameter int unsigned        CLK_DIV     = 50000000,
    parameter int unsigned        MATCH_TIME  = 60,
    parameter int unsigned        WIN_SCORE   = 7,
    parameter logic [BALL_W-1:0]  LEFT_LIMIT  = 10'd20,
    parameter logic [BALL_W-1:0]  RIGHT_LIMIT = 10'd620,
    parameter int unsigned        POINT_PAUSE = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1l,
    input  logic               p1r,
    input  logic               p2l,
    input  logic               p2r,
    input  logic [BALL_W-1:0]  ball_x,
    output logic [STATE_W-1:0] game_state,
    output logic               server,
    output logic               launch,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [TIME_W-1:0]  time_cnt,
    output logic [WIN_W-1:0]   winner
);

    localparam int unsigned PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PAUSE_W = $clog2(POINT_PAUSE + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_DIV - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(POINT_PAUSE - 1);
    localparam logic [TIME_W-1:0]  TIME_END   = TIME_W'(MATCH_TIME);
    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

    btn_press_t press_c;

    btn_press_sync u_sync_p1l (.clk(clk), .reset(reset), .btn_n_i(p1l), .press_c_o(press_c.p1l));
    btn_press_sync u_sync_p1r (.clk(clk), .reset(reset), .btn_n_i(p1r), .press_c_o(press_c.p1r));
    btn_press_sync u_sync_p2l (.clk(clk), .reset(reset), .btn_n_i(p2l), .press_c_o(press_c.p2l));
    btn_press_sync u_sync_p2r (.clk(clk), .reset(reset), .btn_n_i(p2r), .press_c_o(press_c.p2r));

    game_state_e          state_q,  state_d;
    logic                 server_q, server_d;
    logic                 launch_q, launch_d;
    logic [SCORE_W-1:0]   p1_q,     p1_d;
    logic [SCORE_W-1:0]   p2_q,     p2_d;
    logic [TIME_W-1:0]    time_q,   time_d;
    winner_e              winner_q, winner_d;
    logic [PRE_W-1:0]     pre_q,    pre_d;
    logic [PAUSE_W-1:0]   pause_q,  pause_d;

    logic server_press_c;
    logic any_press_c;
    logic miss_left_c;
    logic miss_right_c;

    assign server_press_c = server_q ? (press_c.p2l | press_c.p2r)
                                     : (press_c.p1l | press_c.p1r);
    assign any_press_c    = |press_c;
    assign miss_left_c    = (ball_x <= LEFT_LIMIT);
    assign miss_right_c   = (ball_x >= RIGHT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SERVE;
            server_q <= 1'b0;
            launch_q <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            time_q   <= '0;
            winner_q <= WIN_NONE;
            pre_q    <= '0;
            pause_q  <= '0;
        end else begin
            state_q  <= state_d;
            server_q <= server_d;
            launch_q <= launch_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            time_q   <= time_d;
            winner_q <= winner_d;
            pre_q    <= pre_d;
            pause_q  <= pause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        server_d = server_q;
        launch_d = 1'b0;
        p1_d     = p1_q;
        p2_d     = p2_q;
        time_d   = time_q;
        winner_d = winner_q;
        pre_d    = pre_q;
        pause_d  = pause_q;

        unique case (state_q)
            ST_SERVE: begin
                if (server_press_c) begin
                    launch_d = 1'b1;
                    state_d  = ST_PLAYING;
                end
            end

            ST_PLAYING: begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    time_d = time_inc(time_q);
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
                // A miss outranks a timeout; the timeout is picked up when POINT exits.
                if (miss_left_c) begin
                    p2_d     = score_inc(p2_q);
                    server_d = 1'b0;
                    pause_d  = '0;
                    state_d  = ST_POINT;
                end else if (miss_right_c) begin
                    p1_d     = score_inc(p1_q);
                    server_d = 1'b1;
                    pause_d  = '0;
                    state_d  = ST_POINT;
                end else if (time_q >= TIME_END) begin
                    winner_d = pick_winner(p1_q, p2_q);
                    state_d  = ST_DONE;
                end
            end

            ST_POINT: begin
                if (pause_q == PAUSE_LAST) begin
                    if ((p1_q == SCORE_WIN) || (p2_q == SCORE_WIN) || (time_q >= TIME_END)) begin
                        winner_d = pick_winner(p1_q, p2_q);
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else begin
                    pause_d = pause_q + PAUSE_W'(1);
                end
            end

            ST_DONE: begin
                if (any_press_c) begin
                    p1_d     = '0;
                    p2_d     = '0;
                    time_d   = '0;
                    pre_d    = '0;
                    winner_d = WIN_NONE;
                    server_d = 1'b0;
                    state_d  = ST_SERVE;
                end
            end

            default: begin
                state_d = ST_SERVE;
            end
        endcase
    end

    assign game_state = state_q;
    assign server     = server_q;
    assign launch     = launch_q;
    assign p1_score   = p1_q;
    assign p2_score   = p2_q;
    assign time_cnt   = time_q;
    assign winner     = winner_q;

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Central game controller for the ping-pong design.
- Owns the game state machine: serve, rally, point pause, match end. Also owns scoring, the match clock and server selection.
- Drives game_state to the board controller, ball logic, timer display and matrix display. Issues the one-cycle launch pulse that starts the ball.
- Reads the four active-low player buttons and the ball x position.

Parameters:
- CLK_DIV, 50000000, clk cycles per match-clock second.
- MATCH_TIME, 60, match length in seconds; range 1..63.
- WIN_SCORE, 7, points needed to win; range 1..15.
- LEFT_LIMIT, 10'd20, when ball_x <= LEFT_LIMIT in PLAYING, player 2 scores.
- RIGHT_LIMIT, 10'd620, when ball_x >= RIGHT_LIMIT in PLAYING, player 1 scores. Must exceed LEFT_LIMIT.
- POINT_PAUSE, 25000000, cycles spent in POINT before leaving it; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- p1l  in  1  player 1 left button, active-low, asynchronous
- p1r  in  1  player 1 right button, active-low, asynchronous
- p2l  in  1  player 2 left button, active-low, asynchronous
- p2r  in  1  player 2 right button, active-low, asynchronous
- ball_x  in  10  current ball x position, synchronous to clk
- game_state  out  2  0=SERVE, 1=PLAYING, 2=DONE, 3=POINT
- server  out  1  serving player: 0=P1, 1=P2
- launch  out  1  one-cycle pulse when a serve is accepted
- p1_score  out  4  player 1 points
- p2_score  out  4  player 2 points
- time_cnt  out  6  elapsed match seconds
- winner  out  2  0=none, 1=P1, 2=P2, 3=tie; valid only in DONE

Behaviour:
- Reset (clk edge with reset=1):
  - game_state=SERVE, server=0, launch=0.
  - Scores 0, time_cnt 0, winner 0.
  - Prescaler 0, pause counter 0.
  - Button synchronisers preset to 1 (released).
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a falling-edge detector.
  - Output is a one-cycle press pulse; a held button produces one pulse only.
  - Press pulses are 3 cycles behind the pin.
- SERVE:
  - A press by the server's own buttons (either left or right) fires launch=1 for exactly one cycle and moves to PLAYING on the same edge.
  - Presses by the non-server are ignored.
- PLAYING:
  - Prescaler increments each cycle. When it reaches CLK_DIV-1 it wraps to 0 and time_cnt increments.
  - Prescaler value is held (not cleared) outside PLAYING.
  - ball_x <= LEFT_LIMIT: p2_score+1, server<=0 (the losing player, P1, serves next), go to POINT.
  - ball_x >= RIGHT_LIMIT: p1_score+1, server<=1, go to POINT.
  - If time_cnt reaches MATCH_TIME with no miss that cycle: go to DONE.
  - A miss and a timeout on the same cycle: the point is awarded and the state goes to POINT; the timeout is resolved when POINT exits.
- POINT:
  - Pause counter loads 0 on entry and counts to POINT_PAUSE-1, then the state exits.
  - Exit goes to DONE if either score = WIN_SCORE or time_cnt >= MATCH_TIME; otherwise to SERVE.
  - Buttons are ignored.
- DONE:
  - winner is registered on entry: the higher score wins, equal scores give 3.
  - All outputs hold.
  - Any press from any of the four buttons clears scores, time_cnt, prescaler and winner, sets server=0, and goes to SERVE.
- Arithmetic:
  - Scores saturate at 15.
  - time_cnt saturates at 63.
  - Prescaler width is $clog2(CLK_DIV). Pause counter width is $clog2(POINT_PAUSE+1).
- launch is 0 in every state except the single accept cycle.
- Reset asserted in any state aborts the state immediately; the following cycle shows reset values.

Decomposition:
- Shared package ping_pong_pkg holds:
  - state constants ST_SERVE=0, ST_PLAYING=1, ST_DONE=2, ST_POINT=3;
  - winner codes WIN_NONE/WIN_P1/WIN_P2/WIN_TIE.
- All game-state consumers import these constants.
- One sub-module, btn_press_sync: 2-FF synchroniser plus falling-edge detector with synchronous active-high reset. Instantiated four times.

Test Plan (CLK_DIV=4, MATCH_TIME=3, WIN_SCORE=2, POINT_PAUSE=2, LEFT_LIMIT=20, RIGHT_LIMIT=620):
- Reset, then pulse p2l low -> stays SERVE, launch=0. Pulse p1r low -> 3 cycles later launch=1 for one cycle and game_state=1.
- In PLAYING, drive ball_x=20 -> next cycle p2_score=1, server=0, state=3. After 2 cycles state=0.
- Serve, then ball_x=620 twice across two rallies -> p1_score=2. POINT exits to DONE with winner=1.
- Serve, hold ball_x=300 -> time_cnt steps every 4 cycles. At time_cnt=3, state=2 and winner=3 (0:0).
- ball_x=10 on the same cycle time_cnt reaches 3 -> p2_score+1, state POINT, then DONE with winner=2.
- In DONE, press p2r -> scores 0, time_cnt 0, server 0, state SERVE. Assert reset mid-PLAYING -> all outputs at reset values on the next cycle.
